// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Pure declarations, no logic.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  // Two low cycles let the transmitter's two-flop edge detector re-arm.
  localparam int GAP_CYC      = 2;
  localparam int WDOG_CYC_DEF = 64;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter bundle for uart_tx_arbiter.
// slave = arbiter view, master = requesters plus transmitter view.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_busy;
  logic               send_en;
  logic [7:0]         send_data;
  logic [IDW-1:0]     grant_id;
  logic               tx_done;
  logic               err_timeout;

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, send_en, send_data, grant_id, tx_done, err_timeout
  );

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, send_en, send_data, grant_id, tx_done, err_timeout
  );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational winner search: first set request at or after ptr (wrapping).
// Zero latency; ptr tied to 0 gives fixed lowest-index priority.
module uart_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   idx,
  output logic             vld
);

  logic [N_REQ-1:0] rot;
  logic [IDW-1:0]   off;
  logic [IDW:0]     sum;

  // Rotate so that requester ptr lands on bit 0.
  assign rot = N_REQ'({req, req} >> ptr);

  always_comb begin
    off = '0;
    vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDW'(i);
        vld = 1'b1;
      end
    end
  end

  assign sum = {1'b0, ptr} + {1'b0, off};
  assign idx = (sum >= (IDW+1)'(N_REQ)) ? IDW'(sum - (IDW+1)'(N_REQ)) : sum[IDW-1:0];

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt[i] = vld && (idx == IDW'(i));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ byte sources onto one UART transmitter; UART_ARB_RR_EN selects round-robin, else fixed priority.
// Latency: grant at the IDLE edge, send_en rises on that edge; 1 IDLE + 2 GAP cycles between frames.
// Backpressure: req_ready only in IDLE; watchdog aborts a frame whose tx_busy never rises.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WDOG_CYC = WDOG_CYC_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WDW = $clog2(WDOG_CYC + 1);
  localparam int GCW = $clog2(GAP_CYC + 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYC - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_CYC - 1);

  arb_state_t       state, state_nxt;
  logic [WDW-1:0]   wdog;
  logic [GCW-1:0]   gap_cnt;
  logic [IDW-1:0]   pick_ptr;
  logic [N_REQ-1:0] pick_gnt;
  logic [IDW-1:0]   pick_idx;
  logic             pick_vld;
  logic [7:0]       pick_dat;

  logic [N_REQ-1:0] ready_c;
  logic             xfer;
  logic             send_en_c;
  logic             done_c;
  logic             tmo_c;

  logic             send_en_q;
  logic [7:0]       send_data_q;
  logic [IDW-1:0]   grant_id_q;
  logic             tx_done_q;
  logic             err_timeout_q;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (bus.req_valid),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

`ifdef UART_ARB_RR_EN
  logic [IDW-1:0] rr_ptr;
  logic [IDW:0]   ptr_inc;

  assign ptr_inc  = {1'b0, pick_idx} + (IDW+1)'(1);
  assign pick_ptr = rr_ptr;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (ptr_inc == (IDW+1)'(N_REQ)) ? '0 : ptr_inc[IDW-1:0];
    end
  end
`else
  assign pick_ptr = '0;
`endif

  always_comb begin
    pick_dat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) pick_dat = bus.req_data[8*i +: 8];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_vld) state_nxt = ST_START;
      ST_START: begin
        if (bus.tx_busy)            state_nxt = ST_BUSY;
        else if (wdog == WDOG_LAST) state_nxt = ST_GAP;
      end
      ST_BUSY:  if (!bus.tx_busy) state_nxt = ST_GAP;
      ST_GAP:   if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // req_ready is gated by reset so it drops together with send_en.
  always_comb begin
    ready_c   = '0;
    xfer      = 1'b0;
    send_en_c = 1'b0;
    done_c    = 1'b0;
    tmo_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_c   = sys_rst_n ? pick_gnt : '0;
        xfer      = pick_vld;
        send_en_c = pick_vld;
      end
      ST_START: begin
        send_en_c = !bus.tx_busy && (wdog != WDOG_LAST);
        tmo_c     = !bus.tx_busy && (wdog == WDOG_LAST);
      end
      ST_BUSY:  done_c = !bus.tx_busy;
      default:  ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      send_en_q     <= 1'b0;
      send_data_q   <= '0;
      grant_id_q    <= '0;
      tx_done_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      wdog          <= '0;
      gap_cnt       <= '0;
    end else begin
      send_en_q     <= send_en_c;
      tx_done_q     <= done_c;
      err_timeout_q <= tmo_c;
      if (xfer) begin
        send_data_q <= pick_dat;
        grant_id_q  <= pick_idx;
      end
      // Saturating count; cleared whenever START is entered or left.
      if (state == ST_START && state_nxt == ST_START)
        wdog <= (wdog == WDOG_LAST) ? wdog : wdog + WDW'(1);
      else
        wdog <= '0;
      if (state == ST_GAP && state_nxt == ST_GAP)
        gap_cnt <= gap_cnt + GCW'(1);
      else
        gap_cnt <= '0;
    end
  end

  assign bus.req_ready   = ready_c;
  assign bus.send_en     = send_en_q;
  assign bus.send_data   = send_data_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.tx_done     = tx_done_q;
  assign bus.err_timeout = err_timeout_q;

endmodule
